// File: rtl/bitcoin_result_scan.sv
// Scans NUM_NONCES hash words from shared memory and reports the lowest word below target.
// Define BITCOIN_RESULT_SCAN_EARLY_EXIT_EN to stop at the first passing word instead.
module bitcoin_result_scan #(
   parameter int unsigned NUM_NONCES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] result_addr,
   input  logic [31:0] target,
   output logic        done,
   output logic        found,
   output logic [7:0]  nonce_out,
   output logic [31:0] hash_out,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {StIdle, StWait, StSample} state_e;

   localparam logic [7:0] LastIdx = 8'(NUM_NONCES - 1);

   state_e      state_q;
   logic [31:0] target_q;
   logic [7:0]  idx_q;
   logic        pass;
   logic        last;

   assign mem_clk        = clk;
   assign mem_we         = 1'b0;
   assign mem_write_data = 32'h0;

   assign pass = (mem_read_data < target_q);
   assign last = (idx_q == LastIdx);

   // hash_out doubles as the running best; it starts at all-ones so any passing word beats it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         done      <= 1'b1;
         found     <= 1'b0;
         nonce_out <= 8'h0;
         hash_out  <= 32'hFFFF_FFFF;
         mem_addr  <= 16'h0;
         idx_q     <= 8'h0;
         target_q  <= 32'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  target_q  <= target;
                  mem_addr  <= result_addr;
                  idx_q     <= 8'h0;
                  hash_out  <= 32'hFFFF_FFFF;
                  nonce_out <= 8'h0;
                  found     <= 1'b0;
                  done      <= 1'b0;
                  state_q   <= StWait;
               end
            end
            StWait: begin
               state_q <= StSample;
            end
            StSample: begin
               // Strict compare keeps the earlier index on equal words.
               if (pass && (mem_read_data < hash_out)) begin
                  hash_out  <= mem_read_data;
                  nonce_out <= idx_q;
                  found     <= 1'b1;
               end
`ifdef BITCOIN_RESULT_SCAN_EARLY_EXIT_EN
               if (pass || last) begin
`else
               if (last) begin
`endif
                  done    <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  idx_q    <= idx_q + 8'h1;
                  mem_addr <= mem_addr + 16'h1;
                  state_q  <= StWait;
               end
            end
            default: begin
               done    <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitcoin_result_scan.sv
// Randomized bench for bitcoin_result_scan with a per-cycle behavioural model and directed cases.
module tb_bitcoin_result_scan;

   localparam int N = 16;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] result_addr;
   logic [31:0] target;
   logic        done;
   logic        found;
   logic [7:0]  nonce_out;
   logic [31:0] hash_out;
   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:65535];

   int vecs = 0;
   int errs = 0;

   bitcoin_result_scan #(.NUM_NONCES(N)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .result_addr    (result_addr),
      .target         (target),
      .done           (done),
      .found          (found),
      .nonce_out      (nonce_out),
      .hash_out       (hash_out),
      .mem_clk        (mem_clk),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory: address registered at one edge, data used at the next.
   always @(posedge clk) mem_read_data <= mem[mem_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result after the first m words of a scan: {found, index, hash}.
   function automatic logic [40:0] model(input logic [15:0] base, input logic [31:0] tgt,
                                         input int m);
      logic        f = 1'b0;
      logic [7:0]  ix = 8'h0;
      logic [31:0] best = 32'hFFFF_FFFF;
      for (int k = 0; k < m; k++) begin
         logic [31:0] w = mem[16'(base + k)];
`ifdef BITCOIN_RESULT_SCAN_EARLY_EXIT_EN
         if (w < tgt && !f) begin
            f = 1'b1; ix = 8'(k); best = w;
         end
`else
         if (w < tgt && (!f || w < best)) begin
            f = 1'b1; ix = 8'(k); best = w;
         end
`endif
      end
      return {f, ix, best};
   endfunction

   function automatic int scan_len(input logic [15:0] base, input logic [31:0] tgt);
`ifdef BITCOIN_RESULT_SCAN_EARLY_EXIT_EN
      for (int k = 0; k < N; k++)
         if (mem[16'(base + k)] < tgt) return 2 * (k + 1);
`endif
      return 2 * N;
   endfunction

   logic        m_busy;
   int          m_t;
   int          m_len;
   logic [15:0] m_base;
   logic [31:0] m_tgt;
   logic [40:0] m_res;
   logic [15:0] m_addr;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 1'b0;
         m_t    <= 0;
         m_res  <= {1'b0, 8'h0, 32'hFFFF_FFFF};
         m_addr <= 16'h0;
      end else if (m_busy) begin
         if (m_t + 1 == m_len) begin
            m_busy <= 1'b0;
            m_res  <= model(m_base, m_tgt, N);
            m_addr <= m_base + 16'(m_len / 2 - 1);
         end
         m_t <= m_t + 1;
      end else if (start) begin
         m_busy <= 1'b1;
         m_t    <= 0;
         m_base <= result_addr;
         m_tgt  <= target;
         m_len  <= scan_len(result_addr, target);
      end
   end

   // Per-cycle compare: outputs after edge t of a scan reflect the first t/2 words.
   always @(negedge clk) begin
      logic [40:0] r;
      logic [15:0] ea;
      if (reset_n) begin
         if (m_busy) begin
            r  = model(m_base, m_tgt, m_t / 2);
            ea = m_base + 16'(m_t / 2);
         end else begin
            r  = m_res;
            ea = m_addr;
         end
         chk("done", done, !m_busy);
         chk("found", found, r[40]);
         chk("nonce_out", nonce_out, r[39:32]);
         chk("hash_out", hash_out, r[31:0]);
         chk("mem_addr", mem_addr, ea);
         chk("mem_we", mem_we, 1'b0);
         chk("mem_write_data", mem_write_data, 32'h0);
      end
   end

   task automatic start_scan(input logic [15:0] base, input logic [31:0] tgt);
      @(negedge clk);
      result_addr = base;
      target      = tgt;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts negedges until done; optionally pulses start (with target 0) mid-scan.
   task automatic wait_done(input int pulse_at, output int cyc);
      logic [31:0] keep = target;
      cyc = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         cyc++;
         start  = (cyc == pulse_at);
         target = (cyc == pulse_at) ? 32'h0 : keep;
         if (done) begin
            start  = 1'b0;
            target = keep;
            return;
         end
      end
      errs++;
      $display("FAIL timeout: done never rose, got 0, expected 1");
   endtask

   task automatic fill(input logic [15:0] base, input logic [31:0] v);
      for (int i = 0; i < N; i++) mem[16'(base + i)] = v;
   endtask

   int cyc;

   initial begin
      reset_n     = 1'b0;
      start       = 1'b0;
      result_addr = 16'h0;
      target      = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_done", done, 1'b1);
      chk("rst_found", found, 1'b0);
      chk("rst_nonce", nonce_out, 8'h0);
      chk("rst_hash", hash_out, 32'hFFFF_FFFF);
      chk("rst_addr", mem_addr, 16'h0);
      reset_n = 1'b1;

      // Minimum select with a tie at indices 9 and 12.
      for (int i = 0; i < N; i++) mem[16'h0100 + i] = 32'(100 + i);
      mem[16'h0109] = 32'd7;
      mem[16'h010C] = 32'd7;
      start_scan(16'h0100, 32'd50);
      wait_done(0, cyc);
`ifdef BITCOIN_RESULT_SCAN_EARLY_EXIT_EN
      chk("min_cycles", cyc, 20);
`else
      chk("min_cycles", cyc, 32);
`endif
      chk("min_found", found, 1'b1);
      chk("min_nonce", nonce_out, 8'd9);
      chk("min_hash", hash_out, 32'd7);

      // Equal to target loses.
      fill(16'h0400, 32'h1000);
      start_scan(16'h0400, 32'h1000);
      wait_done(0, cyc);
      chk("strict_found", found, 1'b0);
      chk("strict_nonce", nonce_out, 8'h0);
      chk("strict_hash", hash_out, 32'hFFFF_FFFF);

      // Address wrap with target 0 (never found).
      fill(16'hFFF8, 32'h0);
      start_scan(16'hFFF8, 32'h0);
      chk("wrap_first_addr", mem_addr, 16'hFFF8);
      wait_done(0, cyc);
      chk("wrap_last_addr", mem_addr, 16'h0007);
      chk("wrap_found", found, 1'b0);

      // First pass at 3, minimum at 9; a mid-scan start pulse is ignored.
      fill(16'h0200, 32'd100);
      mem[16'h0203] = 32'd1;
      mem[16'h0209] = 32'd0;
      start_scan(16'h0200, 32'd2);
      wait_done(3, cyc);
`ifdef BITCOIN_RESULT_SCAN_EARLY_EXIT_EN
      chk("ee_cycles", cyc, 8);
      chk("ee_nonce", nonce_out, 8'd3);
      chk("ee_hash", hash_out, 32'd1);
`else
      chk("ee_cycles", cyc, 32);
      chk("ee_nonce", nonce_out, 8'd9);
      chk("ee_hash", hash_out, 32'd0);
`endif
      chk("ee_found", found, 1'b1);

      // Reset mid-scan after word 0 already passed.
      fill(16'h0500, 32'd100);
      mem[16'h0500] = 32'd1;
      start_scan(16'h0500, 32'd50);
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_done", done, 1'b1);
      chk("midrst_found", found, 1'b0);
      chk("midrst_hash", hash_out, 32'hFFFF_FFFF);
      chk("midrst_addr", mem_addr, 16'h0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      start_scan(16'h0100, 32'd50);
      wait_done(0, cyc);
      chk("postrst_nonce", nonce_out, 8'd9);
      chk("postrst_hash", hash_out, 32'd7);

      // Back-to-back with start held high; second scan uses the second target.
      for (int i = 0; i < N; i++) mem[16'h0300 + i] = 32'(100 + i);
      @(negedge clk);
      result_addr = 16'h0300;
      target      = 32'd105;
      start       = 1'b1;
      @(negedge clk);
      chk("b2b_busy", done, 1'b0);
      cyc = 0;
      while (!done && cyc < 600) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b1_done", done, 1'b1);
      chk("b2b1_found", found, 1'b1);
      chk("b2b1_nonce", nonce_out, 8'd0);
      chk("b2b1_hash", hash_out, 32'd100);
      target = 32'd100;
      @(negedge clk);
      chk("b2b_one_cycle", done, 1'b0);
      start = 1'b0;
      wait_done(0, cyc);
      chk("b2b2_found", found, 1'b0);
      chk("b2b2_hash", hash_out, 32'hFFFF_FFFF);

      // Random scans against the model.
      for (int it = 0; it < 25; it++) begin
         logic [15:0] b = 16'($urandom);
         logic [31:0] t = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         for (int i = 0; i < N; i++)
            mem[16'(b + i)] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
         start_scan(b, t);
         wait_done(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20)), cyc);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/bitcoin_result_scan.md
# bitcoin_result_scan

- Reads the per-nonce hash words that the nonce-search engine writes to shared word memory, one 32-bit word per nonce, stored from `result_addr` upward.
- Compares each word against a difficulty target and reports the winning nonce index and its hash word.
- Sits on the same memory port protocol as the hash engine, as the consumer of its output region. It only reads and never writes.

## Interface
Parameters:
- `NUM_NONCES`, default 16: number of consecutive result words to scan (1..256).

Ports:
- `clk`  in  1: single clock. Also drives `mem_clk`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: scan request. Sampled only in IDLE.
- `result_addr`  in  16: word address of the nonce-0 result. Captured on start.
- `target`  in  32: unsigned difficulty threshold. Captured on start.
- `done`  out  1: high in IDLE, low while scanning.
- `found`  out  1: a scanned word was strictly below the target.
- `nonce_out`  out  8: index of the winning word.
- `hash_out`  out  32: value of the winning word.
- `mem_clk`  out  1: equal to `clk`.
- `mem_we`  out  1: tied to 0.
- `mem_addr`  out  16: registered read address.
- `mem_write_data`  out  32: tied to 0.
- `mem_read_data`  in  32: synchronous memory data.

## Operation
States are IDLE, WAIT and SAMPLE.

- **IDLE**
  - `start` high: capture `target`, set `mem_addr <= result_addr`, `idx <= 0`, `best <= 32'hFFFFFFFF`, `best_idx <= 0`, `found <= 0`, then go to WAIT.
  - `start` low: stay in IDLE and hold all results.
- **WAIT**
  - Go to SAMPLE. This is the single memory-latency cycle.
- **SAMPLE**
  - `mem_read_data` is the word at `result_addr + idx`.
  - Candidate test: `mem_read_data < target`, unsigned, strict. A word equal to the target loses.
  - Minimum tracking: if the candidate passes and `mem_read_data < best`, update `best` and `best_idx`. The lowest index wins ties.
  - If `idx == NUM_NONCES-1`, go to IDLE. Otherwise `idx <= idx+1`, `mem_addr <= mem_addr+1`, and go to WAIT.
- **Results**
  - `found` is set whenever any candidate passes.
  - `hash_out` and `nonce_out` reflect `best` and `best_idx`.
  - Results are stable from `done` rising until the next accepted start.
  - When no word passes: `found = 0`, `hash_out = 32'hFFFFFFFF`, `nonce_out = 0`.
- **Address arithmetic**
  - 16-bit, wraps modulo 2^16. For example, `result_addr = 16'hFFFF` reads FFFF, then 0000, and so on.
- **Boundary conditions**
  - `target = 0`: never found.
  - `start` while busy: ignored.
  - `start` held high: a new scan begins on the first IDLE cycle. `done` is high for exactly one cycle between scans.
  - `mem_read_data` outside SAMPLE: ignored.

## Timing
- Reset values: `done=1`, `found=0`, `nonce_out=0`, `hash_out=32'hFFFFFFFF`, `mem_addr=0`, `mem_we=0`, `mem_write_data=0`, state IDLE.
- Memory model:
  - `mem_addr` updates at edge t.
  - Memory registers the address at edge t+1.
  - Data is sampled at edge t+2.
  - Each word costs 2 cycles.
- With start accepted at edge 0:
  - `done` falls after edge 0.
  - Word k is sampled at edge 2(k+1).
  - A full scan returns `done=1` after edge `2*NUM_NONCES`, i.e. edge 32 for the default.
- `found`, `nonce_out` and `hash_out` may change only at SAMPLE edges and on start. They are final when `done` rises.
- Reset mid-scan: immediate return to IDLE with reset values. No partial results survive.

## Configuration
`BITCOIN_RESULT_SCAN_EARLY_EXIT_EN` compiles early exit in or out.

- **Defined**
  - In SAMPLE, the first passing word ends the scan: go to IDLE with `found=1`, `nonce_out=idx`, `hash_out=word`.
  - `done` rises after edge 2(k+1) for a winner at index k.
  - If nothing passes, behaviour equals the full scan.
- **Undefined (default)**
  - Always scan all `NUM_NONCES` words.
  - Report the minimum passing word, as described under Operation.

## Test plan
- **Reset:** assert `reset_n=0` mid-scan (word 5) -> `done=1`, `found=0`, `hash_out=FFFFFFFF`, `mem_addr=0` immediately. The next start scans from scratch.
- **Minimum select:** words = 100+i for i=0..15, except word 9 = 7 and word 12 = 7; target 50 -> `found=1`, `nonce_out=9`, `hash_out=7`, `done` after 32 cycles (default build).
- **Strict compare:** all words = `32'h1000`, target `32'h1000` -> `found=0`, `nonce_out=0`, `hash_out=FFFFFFFF`.
- **Wrap:** `result_addr=16'hFFF8`, `NUM_NONCES=16` -> read addresses FFF8..FFFF then 0000..0007 in order. `mem_we` stays 0 throughout.
- **Early exit** (macro defined): word 3 = 1, word 9 = 0, target 2 -> `found=1`, `nonce_out=3`, `hash_out=1`, `done` after edge 8. A start pulse during the scan is ignored.
- **Back-to-back:** `start` held high across two scans with different `target` values -> `done` is high for exactly 1 cycle between scans. The second result uses the second target.
